// File: rtl/outbuf_drain_pkg.sv
// Shared types and constants for the output-buffer drain block.
package outbuf_drain_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, READ, FLUSH, DONE_S} state_t;

    localparam int LANE_W = 16;
    localparam int LANES  = 4;
    localparam int M_MSB  = 11;
    localparam int M_LSB  = 8;

    // Zero every negative 16-bit lane of a result word.
    function automatic logic [LANES*LANE_W-1:0] relu_word(input logic [LANES*LANE_W-1:0] w);
        logic [LANES*LANE_W-1:0] r;
        r = w;
        for (int i = 0; i < LANES; i++)
            if (w[i*LANE_W + LANE_W-1]) r[i*LANE_W +: LANE_W] = '0;
        return r;
    endfunction

endpackage

// File: rtl/outbuf_drain_if.sv
// Output-buffer read port plus result stream; master = drain block, slave = SRAM/consumer side.
interface outbuf_drain_if #(
    parameter int DW = 64,
    parameter int AW = 4
);
    logic          EN_O;
    logic          RW_O;
    logic [AW-1:0] ADDR_O;
    logic [DW-1:0] RDATA_O;
    logic          M_VALID;
    logic          M_READY;
    logic [DW-1:0] M_DATA;
    logic          M_LAST;

    modport master (output EN_O, RW_O, ADDR_O, M_VALID, M_DATA, M_LAST,
                    input  RDATA_O, M_READY);
    modport slave  (input  EN_O, RW_O, ADDR_O, M_VALID, M_DATA, M_LAST,
                    output RDATA_O, M_READY);
endinterface

// File: rtl/outbuf_drain_fifo.sv
// Small fall-through FIFO: a word written while empty is visible at the head the same cycle.
module outbuf_drain_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [W-1:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wptr, rptr;
    logic                    empty, rd, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign rd_valid = !empty || wr_en;
    assign rd_data  = !empty ? mem[rptr] : (wr_en ? wr_data : '0);
    assign rd       = rd_valid && rd_ready;
    // A word consumed on arrival into an empty FIFO is never stored.
    assign push     = wr_en && !(empty && rd);
    assign pop      = rd && !empty;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= inc(wptr);
            if (pop)  rptr <= inc(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
        !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: rtl/outbuf_drain.sv
// Drains one tile of result words from the output buffer into a valid/ready stream.
// Optional OUTBUF_DRAIN_RELU_EN zeroes negative 16-bit lanes on FIFO entry.
module outbuf_drain
    import outbuf_drain_pkg::*;
#(
    parameter int DW         = 64,
    parameter int AW         = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  START,
    input  logic [11:0]           MNT,
    outbuf_drain_if.master        bus,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int MW = M_MSB - M_LSB + 1;
    localparam int CW = $clog2(FIFO_DEPTH+1);

    state_t        state, nxt_state;
    logic [MW-1:0] wcnt;
    logic [AW-1:0] rd_ptr, addr_hold, last_addr;
    logic          inflight, inflight_last;
    logic          issue, pop, credit_ok, is_last_rd;
    logic [CW-1:0] fcount;
    logic [CW:0]   occ;
    logic [DW-1:0] word_in;
    logic [DW:0]   head;
    logic          unused_mnt;

    assign unused_mnt = ^MNT[M_LSB-1:0];

`ifdef OUTBUF_DRAIN_RELU_EN
    assign word_in = relu_word(bus.RDATA_O);
`else
    assign word_in = bus.RDATA_O;
`endif

    outbuf_drain_fifo #(.W(DW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .wr_en    (inflight),
        .wr_data  ({inflight_last, word_in}),
        .rd_valid (bus.M_VALID),
        .rd_ready (bus.M_READY),
        .rd_data  (head),
        .count    (fcount)
    );

    assign bus.M_LAST = head[DW];
    assign bus.M_DATA = head[DW-1:0];
    assign bus.RW_O   = 1'b0;

    // Credit counts stored words plus the read in flight; a pop this cycle frees a slot.
    assign pop        = bus.M_VALID && bus.M_READY;
    assign occ        = {1'b0, fcount} + (CW+1)'(inflight);
    assign credit_ok  = occ < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
    assign last_addr  = AW'(wcnt - 1'b1);
    assign is_last_rd = (rd_ptr == last_addr);

    always_comb begin
        nxt_state = state;
        issue     = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE:   if (START) nxt_state = LOAD;
            LOAD: begin
                BUSY      = 1'b1;
                nxt_state = (wcnt == '0) ? DONE_S : READ;
            end
            READ: begin
                BUSY  = 1'b1;
                issue = credit_ok;
                if (issue && is_last_rd) nxt_state = FLUSH;
            end
            FLUSH: begin
                BUSY = 1'b1;
                if (pop && bus.M_LAST) nxt_state = DONE_S;
            end
            DONE_S: begin
                DONE      = 1'b1;
                nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign bus.EN_O   = issue;
    assign bus.ADDR_O = issue ? rd_ptr : addr_hold;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state         <= IDLE;
            wcnt          <= '0;
            rd_ptr        <= '0;
            addr_hold     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= nxt_state;
            inflight      <= issue;
            inflight_last <= issue && is_last_rd;
            if (state == IDLE && START) begin
                wcnt   <= MNT[M_MSB:M_LSB];
                rd_ptr <= '0;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 1'b1;
                addr_hold <= rd_ptr;
            end
        end
    end

endmodule
